// File: rtl/zedinterp.sv
// Z interpolator: walks a 16.16 Z value across 4-pixel phrases.
// Each phrase carries the integer Z of four consecutive pixels.

module zedinterp_lane #(
  parameter int unsigned LANE = 0
) (
  input  logic [31:0] base,
  input  logic [31:0] inc,
  output logic [15:0] z
);
  // Integer part only; fractional bits are truncated.
  assign z = 16'((base + 32'(LANE) * inc) >> 16);
endmodule

module zedinterp (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic        zload,
  input  logic [31:0] zstart,
  input  logic [31:0] zinc,
  input  logic [9:0]  zcount,
  input  logic        zout_ready,
  output logic [31:0] srczplo,
  output logic [31:0] srczphi,
  output logic        zout_valid,
  output logic        zbusy,
  output logic        zdone
);
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned VEC_W     = 16;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                             state_q, state_d;
  logic [31:0]                        acc_q, acc_d;
  logic [31:0]                        zinc_q, zinc_d;
  logic [9:0]                         remaining_q, remaining_d;
  logic [NUM_LANES-1:0][VEC_W-1:0]    srcz_q, srcz_d, lane_z;
  logic                               zout_valid_q, zout_valid_d;
  logic                               zbusy_q, zbusy_d;
  logic                               zdone_q, zdone_d;
  logic                               accept, phrase_ld;

  // Lanes see the next accumulator value so a phrase is registered on the
  // same edge the accumulator advances.
  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      zedinterp_lane #(.LANE(g)) u_lane (
        .base (acc_d),
        .inc  (zinc_q),
        .z    (lane_z[g])
      );
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    zinc_d       = zinc_q;
    remaining_d  = remaining_q;
    zout_valid_d = zout_valid_q;
    phrase_ld    = 1'b0;
    accept       = zout_valid_q & zout_ready;
    if (zload) begin
      state_d      = LOAD;
      acc_d        = zstart;
      zinc_d       = zinc;
      remaining_d  = zcount;
      zout_valid_d = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (remaining_q == 10'd0) begin
            state_d = DONE;
          end else begin
            phrase_ld    = 1'b1;
            zout_valid_d = 1'b1;
            state_d      = RUN;
          end
        end
        RUN: begin
          if (accept) begin
            acc_d       = acc_q + (zinc_q << 2);
            remaining_d = remaining_q - 10'd1;
            if (remaining_q > 10'd1) begin
              phrase_ld = 1'b1;
            end else begin
              zout_valid_d = 1'b0;
              state_d      = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
    srcz_d  = phrase_ld ? lane_z : srcz_q;
    zdone_d = (state_d == DONE);
    zbusy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      zinc_q       <= '0;
      remaining_q  <= '0;
      srcz_q       <= '0;
      zout_valid_q <= 1'b0;
      zbusy_q      <= 1'b0;
      zdone_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      zinc_q       <= zinc_d;
      remaining_q  <= remaining_d;
      srcz_q       <= srcz_d;
      zout_valid_q <= zout_valid_d;
      zbusy_q      <= zbusy_d;
      zdone_q      <= zdone_d;
    end
  end

  assign srczplo    = srcz_q[1:0];
  assign srczphi    = srcz_q[3:2];
  assign zout_valid = zout_valid_q;
  assign zbusy      = zbusy_q;
  assign zdone      = zdone_q;
endmodule

// File: tb/tb_zedinterp.sv
// Directed bench for zedinterp: phrase values, latency, backpressure,
// zero count, abort by zload and by reset.

module tb_zedinterp;
  logic        sys_clk = 1'b0;
  logic        resetl;
  logic        zload;
  logic [31:0] zstart;
  logic [31:0] zinc;
  logic [9:0]  zcount;
  logic        zout_ready;
  logic [31:0] srczplo, srczphi;
  logic        zout_valid, zbusy, zdone;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int d0;

  zedinterp dut (
    .sys_clk    (sys_clk),
    .resetl     (resetl),
    .zload      (zload),
    .zstart     (zstart),
    .zinc       (zinc),
    .zcount     (zcount),
    .zout_ready (zout_ready),
    .srczplo    (srczplo),
    .srczphi    (srczphi),
    .zout_valid (zout_valid),
    .zbusy      (zbusy),
    .zdone      (zdone)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (zdone === 1'b1) done_cnt++;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic load(input logic [31:0] zs, input logic [31:0] zi, input logic [9:0] zc);
    zload = 1'b1; zstart = zs; zinc = zi; zcount = zc;
    step();
    zload = 1'b0; zstart = 32'hDEADBEEF; zinc = 32'h12345678; zcount = 10'h3FF;
  endtask

  task automatic test_reset();
    resetl = 1'b0; zload = 1'b0; zstart = '0; zinc = '0; zcount = '0; zout_ready = 1'b0;
    #2;
    checks++; if (srczplo !== 32'h0 || srczphi !== 32'h0) begin errors++;
      $display("FAIL reset_data got %h/%h exp 0/0", srczplo, srczphi); end
    checks++; if ({zout_valid, zbusy, zdone} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got %b exp 000", {zout_valid, zbusy, zdone}); end
    step(); step();
    resetl = 1'b1;
    step();
    checks++; if ({zout_valid, zbusy, zdone} !== 3'b000) begin errors++;
      $display("FAIL reset_idle got %b exp 000", {zout_valid, zbusy, zdone}); end
  endtask

  task automatic test_basic();
    zout_ready = 1'b1;
    d0 = done_cnt;
    load(32'h00100000, 32'h00010000, 10'd2);
    checks++; if ({zout_valid, zbusy, zdone} !== 3'b010) begin errors++;
      $display("FAIL basic_load got v/b/d=%b exp 010", {zout_valid, zbusy, zdone}); end
    step();
    checks++; if (zout_valid !== 1'b1 || srczplo !== 32'h00110010 || srczphi !== 32'h00130012) begin errors++;
      $display("FAIL basic_p0 got v=%b %h/%h exp 1 00110010/00130012", zout_valid, srczplo, srczphi); end
    step();
    checks++; if (zout_valid !== 1'b1 || srczplo !== 32'h00150014 || srczphi !== 32'h00170016) begin errors++;
      $display("FAIL basic_p1 got v=%b %h/%h exp 1 00150014/00170016", zout_valid, srczplo, srczphi); end
    step();
    checks++; if ({zout_valid, zbusy, zdone} !== 3'b011) begin errors++;
      $display("FAIL basic_done got v/b/d=%b exp 011", {zout_valid, zbusy, zdone}); end
    step();
    checks++; if ({zout_valid, zbusy, zdone} !== 3'b000 || done_cnt - d0 !== 1) begin errors++;
      $display("FAIL basic_idle got v/b/d=%b dones=%0d exp 000 1", {zout_valid, zbusy, zdone}, done_cnt - d0); end
  endtask

  task automatic test_fraction();
    zout_ready = 1'b1;
    load(32'h00008000, 32'h00008000, 10'd1);
    step();
    checks++; if (zout_valid !== 1'b1 || srczplo !== 32'h00010000 || srczphi !== 32'h00020001) begin errors++;
      $display("FAIL fraction got v=%b %h/%h exp 1 00010000/00020001", zout_valid, srczplo, srczphi); end
    step(); step();
  endtask

  task automatic test_wrap();
    zout_ready = 1'b1;
    load(32'hFFFF0000, 32'h00010000, 10'd1);
    step();
    checks++; if (zout_valid !== 1'b1 || srczplo !== 32'h0000FFFF || srczphi !== 32'h00020001) begin errors++;
      $display("FAIL wrap_pos got v=%b %h/%h exp 1 0000ffff/00020001", zout_valid, srczplo, srczphi); end
    step(); step();
    load(32'h00100000, 32'hFFFF0000, 10'd2);
    step();
    checks++; if (zout_valid !== 1'b1 || srczplo !== 32'h000F0010 || srczphi !== 32'h000D000E) begin errors++;
      $display("FAIL wrap_neg got v=%b %h/%h exp 1 000f0010/000d000e", zout_valid, srczplo, srczphi); end
    step();
    checks++; if (srczplo !== 32'h000B000C || srczphi !== 32'h0009000A) begin errors++;
      $display("FAIL wrap_neg_p1 got %h/%h exp 000b000c/0009000a", srczplo, srczphi); end
    step(); step();
  endtask

  task automatic test_backpressure();
    zout_ready = 1'b0;
    d0 = done_cnt;
    load(32'h00000000, 32'h00010000, 10'd3);
    step();
    checks++; if (zout_valid !== 1'b1 || srczplo !== 32'h00010000 || srczphi !== 32'h00030002) begin errors++;
      $display("FAIL bp_p0 got v=%b %h/%h exp 1 00010000/00030002", zout_valid, srczplo, srczphi); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (zout_valid !== 1'b1 || srczplo !== 32'h00010000 || srczphi !== 32'h00030002) begin errors++;
        $display("FAIL bp_hold%0d got v=%b %h/%h exp 1 00010000/00030002", i, zout_valid, srczplo, srczphi); end
    end
    zout_ready = 1'b1;
    step();
    checks++; if (zout_valid !== 1'b1 || srczplo !== 32'h00050004 || srczphi !== 32'h00070006) begin errors++;
      $display("FAIL bp_p1 got v=%b %h/%h exp 1 00050004/00070006", zout_valid, srczplo, srczphi); end
    step();
    checks++; if (zout_valid !== 1'b1 || srczplo !== 32'h00090008 || srczphi !== 32'h000B000A) begin errors++;
      $display("FAIL bp_p2 got v=%b %h/%h exp 1 00090008/000b000a", zout_valid, srczplo, srczphi); end
    step(); step(); step();
    checks++; if (done_cnt - d0 !== 1 || zbusy !== 1'b0) begin errors++;
      $display("FAIL bp_dones got dones=%0d busy=%b exp 1 0", done_cnt - d0, zbusy); end
  endtask

  task automatic test_zero_count();
    zout_ready = 1'b1;
    load(32'h00100000, 32'h00010000, 10'd0);
    checks++; if ({zout_valid, zbusy, zdone} !== 3'b010) begin errors++;
      $display("FAIL zero_c1 got v/b/d=%b exp 010", {zout_valid, zbusy, zdone}); end
    step();
    checks++; if ({zout_valid, zbusy, zdone} !== 3'b011) begin errors++;
      $display("FAIL zero_c2 got v/b/d=%b exp 011", {zout_valid, zbusy, zdone}); end
    step();
    checks++; if ({zout_valid, zbusy, zdone} !== 3'b000) begin errors++;
      $display("FAIL zero_c3 got v/b/d=%b exp 000", {zout_valid, zbusy, zdone}); end
  endtask

  task automatic test_abort();
    zout_ready = 1'b1;
    d0 = done_cnt;
    load(32'h00100000, 32'h00010000, 10'd5);
    step(); step();
    checks++; if (zout_valid !== 1'b1 || srczplo !== 32'h00150014) begin errors++;
      $display("FAIL abort_old got v=%b %h exp 1 00150014", zout_valid, srczplo); end
    load(32'h00200000, 32'h00010000, 10'd1);
    checks++; if ({zout_valid, zbusy, zdone} !== 3'b010) begin errors++;
      $display("FAIL abort_reload got v/b/d=%b exp 010", {zout_valid, zbusy, zdone}); end
    step();
    checks++; if (zout_valid !== 1'b1 || srczplo !== 32'h00210020 || srczphi !== 32'h00230022) begin errors++;
      $display("FAIL abort_new got v=%b %h/%h exp 1 00210020/00230022", zout_valid, srczplo, srczphi); end
    step(); step();
    checks++; if (done_cnt - d0 !== 1 || zbusy !== 1'b0) begin errors++;
      $display("FAIL abort_dones got dones=%0d busy=%b exp 1 0", done_cnt - d0, zbusy); end
    d0 = done_cnt;
    load(32'h00300000, 32'h00010000, 10'd5);
    step(); step();
    resetl = 1'b0;
    #1;
    checks++; if (srczplo !== 32'h0 || srczphi !== 32'h0 || {zout_valid, zbusy, zdone} !== 3'b000) begin errors++;
      $display("FAIL abort_rst got %h/%h v/b/d=%b exp 0/0 000", srczplo, srczphi, {zout_valid, zbusy, zdone}); end
    step();
    resetl = 1'b1;
    step(); step(); step();
    checks++; if ({zout_valid, zbusy, zdone} !== 3'b000 || done_cnt !== d0) begin errors++;
      $display("FAIL abort_post got v/b/d=%b dones=%0d exp 000 0", {zout_valid, zbusy, zdone}, done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fraction();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/zedinterp.md
ZEDINTERP -- requirements
Module: zedinterp

Interface
REQ-001 SHALL have port: sys_clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: resetl  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: zload  input  1  start/restart pulse, sampled on sys_clk.
REQ-004 SHALL have port: zstart  input  32  Z of pixel 0, unsigned 16.16 fixed point, sampled with zload.
REQ-005 SHALL have port: zinc  input  32  per-pixel Z increment, two's-complement 16.16, sampled with zload.
REQ-006 SHALL have port: zcount  input  10  number of phrases to produce, sampled with zload.
REQ-007 SHALL have port: zout_ready  input  1  downstream comparator accepts the current phrase.
REQ-008 SHALL have port: srczplo  output  32  [15:0] = pixel 0 Z, [31:16] = pixel 1 Z.
REQ-009 SHALL have port: srczphi  output  32  [15:0] = pixel 2 Z, [31:16] = pixel 3 Z.
REQ-010 SHALL have port: zout_valid  output  1  srczplo/srczphi hold a valid phrase.
REQ-011 SHALL have port: zbusy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port: zdone  output  1  one-cycle pulse at end of run.

Function
REQ-013 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-014 SHALL, on zload=1 in any state, capture zstart into the 32-bit accumulator acc, capture zinc, capture zcount into remaining, and enter LOAD; an in-progress run is abandoned without zdone.
REQ-015 SHALL, in LOAD: if remaining=0, go to DONE with zout_valid never asserted; otherwise register the phrase from acc, set zout_valid=1 and go to RUN.
REQ-016 SHALL compute pixel k (k=0..3) Z as bits [31:16] of (acc + k*zinc) mod 2^32; fractional bits are truncated, not rounded.
REQ-017 SHALL give first-phrase latency of 2 edges: zload sampled at edge t, zout_valid=1 after edge t+1.
REQ-018 SHALL treat a phrase as accepted on an edge where zout_valid=1 and zout_ready=1.
REQ-019 SHALL, on acceptance, set acc = acc + 4*zinc (mod 2^32) and decrement remaining.
REQ-020 SHALL, on acceptance with remaining>1, register the next phrase on the same edge with zout_valid kept at 1, giving one phrase per cycle while zout_ready is held high.
REQ-021 SHALL, on acceptance with remaining=1, clear zout_valid and enter DONE.
REQ-022 SHALL hold srczplo, srczphi and zout_valid stable while zout_valid=1 and zout_ready=0.
REQ-023 SHALL assert zdone=1 for exactly the one cycle spent in DONE, then enter IDLE.
REQ-024 SHALL give zload priority over acceptance and over DONE when both occur on the same edge.
REQ-025 SHALL ignore zout_ready while zout_valid=0.
REQ-026 SHALL let accumulator and increment arithmetic wrap modulo 2^32 with no saturation and no flag.

Reset
REQ-027 SHALL, while resetl=0, force IDLE with acc=0, remaining=0, zinc register=0, srczplo=0, srczphi=0, zout_valid=0, zbusy=0, zdone=0, regardless of sys_clk.
REQ-028 SHALL, on resetl asserted mid-run, discard the run with no zdone, and SHALL require a new zload after release.

Verification
REQ-029 Basic: zstart=0x00100000, zinc=0x00010000, zcount=2, ready=1 -> srczplo/hi=0x00110010/0x00130012, then 0x00150014/0x00170016 on consecutive cycles; zdone on the following cycle.
REQ-030 Fraction: zstart=0x00008000, zinc=0x00008000, zcount=1 -> srczplo=0x00010000, srczphi=0x00020001.
REQ-031 Wrap/negative: zstart=0xFFFF0000, zinc=0x00010000 -> lo=0x0000FFFF, hi=0x00020001; zstart=0x00100000, zinc=0xFFFF0000 -> lo=0x000F0010, hi=0x000D000E.
REQ-032 Backpressure: zcount=3, ready low 3 cycles during phrase 1 -> outputs and valid unchanged; all 3 phrases in order; exactly one zdone.
REQ-033 Zero count: zcount=0 -> zbusy high for 2 cycles, zdone pulse, zout_valid never high.
REQ-034 Abort: zload during RUN with new zstart, and resetl low mid-run -> old phrases dropped, no zdone for the old run; new run starts correctly, or all outputs are 0 after reset.
